// File: rtl/multi_channel_window_buffer.sv
// Multi-channel sliding sample window with threshold trigger,
// post-trigger capture and coherent freeze for the DOA correlator.
module multi_channel_window_buffer #(
  parameter int WIDTH     = 18,
  parameter int DEPTH     = 256,
  parameter int CHANNELS  = 4,
  parameter int POST_TRIG = 128,
  localparam int TW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [CHANNELS-1:0][WIDTH-1:0]           data,
  input  logic                                     data_rdy,
  input  logic [WIDTH-2:0]                         threshold,
  input  logic                                     window_ack,
  output logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] window,
  output logic                                     noise_detected,
  output logic                                     window_valid,
  output logic [TW-1:0]                            trig_channel,
  output logic                                     overrun
);

  typedef enum logic [1:0] {
    FILL,
    ARMED,
    POST,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]       fill_cnt;
  logic [CW-1:0]       post_cnt;
  logic [CHANNELS-1:0] exceed;
  logic [TW-1:0]       low_idx;
  logic                accept;
  logic                fill_done;
  logic                post_done;
  logic                trig_hit;

  assign accept    = data_rdy && (state != HOLD);
  assign fill_done = fill_cnt == CW'(DEPTH - POST_TRIG - 2);
  assign post_done = post_cnt == CW'(POST_TRIG - 1);
  assign trig_hit  = |exceed;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_mag
    logic [WIDTH-1:0] neg;
    logic [WIDTH-2:0] mag;
    always_comb begin
      neg = '0 - data[c];
      if (!data[c][WIDTH-1])
        mag = data[c][WIDTH-2:0];
      // only the most negative value negates to itself
      else if (neg[WIDTH-1])
        mag = '1;
      else
        mag = neg[WIDTH-2:0];
    end
    assign exceed[c] = mag > threshold;
  end

  always_comb begin
    low_idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (exceed[c])
        low_idx = TW'(c);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:
        if (accept && fill_done)
          state_nxt = ARMED;
      ARMED:
        if (accept && trig_hit)
          state_nxt = POST;
      POST:
        if (accept && post_done)
          state_nxt = HOLD;
      HOLD:
        if (window_ack)
          state_nxt = FILL;
      default:
        state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= FILL;
      fill_cnt       <= '0;
      post_cnt       <= '0;
      window         <= '0;
      noise_detected <= 1'b0;
      window_valid   <= 1'b0;
      trig_channel   <= '0;
      overrun        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        for (int c = 0; c < CHANNELS; c++)
          window[c] <= {window[c][DEPTH-2:0], data[c]};
      if (state == FILL && accept)
        fill_cnt <= fill_cnt + 1'b1;
      if (state == ARMED && accept && trig_hit) begin
        noise_detected <= 1'b1;
        trig_channel   <= low_idx;
        post_cnt       <= '0;
      end
      if (state == POST && accept) begin
        post_cnt <= post_cnt + 1'b1;
        if (post_done)
          window_valid <= 1'b1;
      end
      if (state == HOLD) begin
        if (window_ack) begin
          window_valid   <= 1'b0;
          noise_detected <= 1'b0;
          overrun        <= 1'b0;
          fill_cnt       <= '0;
        end else if (data_rdy) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_window_buffer.sv
// Randomised and directed bench for multi_channel_window_buffer,
// checked against a queue-free array history model.
module tb_multi_channel_window_buffer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                     s_reset, s_rdy, s_ack;
  logic [1:0][17:0]         s_data;
  logic [16:0]              s_thr;
  logic [1:0][7:0][17:0]    s_window;
  logic                     s_noise, s_valid, s_ovr;
  logic [0:0]               s_trig;

  logic                     b_reset, b_rdy, b_ack;
  logic [3:0][17:0]         b_data;
  logic [16:0]              b_thr;
  logic [3:0][255:0][17:0]  b_window;
  logic                     b_noise, b_valid, b_ovr;
  logic [1:0]               b_trig;

  multi_channel_window_buffer #(
    .WIDTH(18), .DEPTH(8), .CHANNELS(2), .POST_TRIG(3)
  ) u_small (
    .clock(clock), .reset(s_reset), .data(s_data),
    .data_rdy(s_rdy), .threshold(s_thr), .window_ack(s_ack),
    .window(s_window), .noise_detected(s_noise),
    .window_valid(s_valid), .trig_channel(s_trig),
    .overrun(s_ovr)
  );

  multi_channel_window_buffer u_big (
    .clock(clock), .reset(b_reset), .data(b_data),
    .data_rdy(b_rdy), .threshold(b_thr), .window_ack(b_ack),
    .window(b_window), .noise_detected(b_noise),
    .window_valid(b_valid), .trig_channel(b_trig),
    .overrun(b_ovr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model: phase 0 fill, 1 armed, 2 capture, 3 frozen
  int m_d, m_p, m_c;
  int hist[4][256];
  int phase, n_acc, n_post;
  int m_noise, m_valid, m_trig, m_ovr;
  int xin[4];
  int sel;
  int thr_g;
  bit full_chk;

  function automatic int mag(input int x);
    int m;
    m = (x < 0) ? -x : x;
    if (m > 131071) m = 131071;
    return m;
  endfunction

  task automatic model_step(input bit rst, input bit rdy,
                            input int thr, input bit ack);
    int hit;
    if (rst) begin
      foreach (hist[c, k]) hist[c][k] = 0;
      phase = 0; n_acc = 0; n_post = 0;
      m_noise = 0; m_valid = 0; m_trig = 0; m_ovr = 0;
    end else if (phase == 3) begin
      if (ack) begin
        phase = 0; n_acc = 0;
        m_valid = 0; m_noise = 0; m_ovr = 0;
      end else if (rdy) begin
        m_ovr = 1;
      end
    end else if (rdy) begin
      hit = -1;
      if (phase == 1)
        for (int c = 0; c < m_c; c++)
          if (hit < 0 && mag(xin[c]) > thr) hit = c;
      for (int c = 0; c < m_c; c++) begin
        for (int k = m_d - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = xin[c];
      end
      if (phase == 0) begin
        n_acc++;
        if (n_acc == m_d - m_p - 1) phase = 1;
      end else if (phase == 1) begin
        if (hit >= 0) begin
          phase = 2; m_noise = 1; m_trig = hit; n_post = 0;
        end
      end else begin
        n_post++;
        if (n_post == m_p) begin
          phase = 3; m_valid = 1;
        end
      end
    end
  endtask

  task automatic compare();
    if (sel == 0) begin
      check("s_noise", s_noise, m_noise);
      check("s_valid", s_valid, m_valid);
      check("s_trig", s_trig, m_trig);
      check("s_ovr", s_ovr, m_ovr);
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 8; k++)
          check($sformatf("s_win[%0d][%0d]", c, k),
                $signed(s_window[c][k]), hist[c][k]);
    end else begin
      check("b_noise", b_noise, m_noise);
      check("b_valid", b_valid, m_valid);
      check("b_trig", b_trig, m_trig);
      check("b_ovr", b_ovr, m_ovr);
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 256; k++)
          if (full_chk || k == 0 || k == 128 || k == 255)
            check($sformatf("b_win[%0d][%0d]", c, k),
                  $signed(b_window[c][k]), hist[c][k]);
    end
  endtask

  task automatic step(input bit rst, input bit rdy, input bit ack);
    s_reset = (sel == 0) && rst;
    s_rdy   = (sel == 0) && rdy;
    s_ack   = (sel == 0) && ack;
    b_reset = (sel == 1) && rst;
    b_rdy   = (sel == 1) && rdy;
    b_ack   = (sel == 1) && ack;
    for (int c = 0; c < 2; c++) s_data[c] = xin[c][17:0];
    for (int c = 0; c < 4; c++) b_data[c] = xin[c][17:0];
    s_thr = thr_g[16:0];
    b_thr = thr_g[16:0];
    @(posedge clock);
    model_step(rst, rdy, thr_g, ack);
    #1;
    compare();
  endtask

  task automatic feed(input int a, input int b);
    xin[0] = a; xin[1] = b; xin[2] = 0; xin[3] = 0;
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle_ack();
    xin[0] = 0; xin[1] = 0;
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int acc;
    int waited;
    sel = 0; full_chk = 0; thr_g = 50;
    m_d = 8; m_p = 3; m_c = 2;
    foreach (xin[i]) xin[i] = 0;
    b_reset = 1'b1; b_rdy = 1'b0; b_ack = 1'b0;
    b_data = '0; b_thr = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("rst_win", s_window, 0);

    // ramp: arms after 4, only >50 triggers
    for (int n = 1; n <= 10; n++) feed(n, n);
    check("ramp_noise", s_noise, 0);
    feed(50, 50);
    check("eq_thr_noise", s_noise, 0);
    feed(51, 51);
    check("t1_noise", s_noise, 1);
    check("t1_trig", s_trig, 0);
    feed(52, 52); feed(53, 53); feed(54, 54);
    check("t1_valid", s_valid, 1);
    check("t1_w03", $signed(s_window[0][3]), 51);

    // overrun while frozen, then ack with data_rdy high
    for (int i = 0; i < 5; i++) feed(999, 999);
    check("ovr_set", s_ovr, 1);
    check("ovr_w00", $signed(s_window[0][0]), 54);
    xin[0] = 7; xin[1] = 7;
    step(1'b0, 1'b1, 1'b1);
    check("ack_ovr", s_ovr, 0);
    check("ack_valid", s_valid, 0);
    check("ack_w00", $signed(s_window[0][0]), 54);
    for (int i = 0; i < 4; i++) feed(70, 70);
    check("refill_noise", s_noise, 0);
    feed(70, 70);
    check("both_trig", s_trig, 0);
    check("both_noise", s_noise, 1);
    feed(0, 0); feed(0, 0); feed(0, 0);
    idle_ack();

    // saturated most-negative magnitude
    for (int i = 0; i < 4; i++) feed(0, 0);
    feed(50, -50);
    check("neg_eq_noise", s_noise, 0);
    thr_g = 131070;
    feed(0, -131072);
    check("sat_noise", s_noise, 1);
    check("sat_trig", s_trig, 1);

    // reset two samples into capture
    thr_g = 50;
    feed(3, 4); feed(5, 6);
    step(1'b1, 1'b1, 1'b0);
    check("mid_rst_noise", s_noise, 0);
    check("mid_rst_win", s_window, 0);
    for (int i = 0; i < 4; i++) feed(0, 0);
    feed(0, -60);
    check("t2_noise", s_noise, 1);
    check("t2_trig", s_trig, 1);
    feed(0, 0); feed(0, 0);
    check("t2_not_yet", s_valid, 0);
    feed(0, 0);
    check("t2_valid", s_valid, 1);
    check("t2_w13", $signed(s_window[1][3]), -60);
    idle_ack();

    // zero threshold
    thr_g = 0;
    for (int i = 0; i < 4; i++) feed(0, 0);
    feed(0, 0);
    check("thr0_zero", s_noise, 0);
    feed(0, 1);
    check("thr0_one", s_noise, 1);
    feed(0, 0); feed(0, 0); feed(0, 0);
    idle_ack();

    // random traffic, stray acks and resets
    for (int i = 0; i < 400; i++) begin
      xin[0] = int'($urandom_range(0, 200)) - 100;
      xin[1] = int'($urandom_range(0, 200)) - 100;
      thr_g  = int'($urandom_range(30, 110));
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0);
    end

    // default config: gapped random stream, impulse on ch2
    sel = 1; m_d = 256; m_p = 128; m_c = 4; thr_g = 500;
    s_rdy = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    acc = 0;
    while (acc < 200) begin
      bit rdy;
      rdy = $urandom_range(0, 2) != 0;
      for (int c = 0; c < 4; c++)
        xin[c] = rdy ? int'($urandom_range(0, 998)) - 499
                     : int'($urandom_range(0, 4000)) - 2000;
      step(1'b0, rdy, 1'b0);
      if (rdy) acc++;
    end
    check("b_pre_noise", b_noise, 0);
    for (int c = 0; c < 4; c++)
      xin[c] = int'($urandom_range(0, 998)) - 499;
    xin[2] = 1000;
    step(1'b0, 1'b1, 1'b0);
    check("b_noise_on", b_noise, 1);
    check("b_trig_ch", b_trig, 2);
    waited = 0;
    while (!b_valid && waited < 2000) begin
      bit rdy;
      rdy = $urandom_range(0, 2) != 0;
      for (int c = 0; c < 4; c++)
        xin[c] = rdy ? int'($urandom_range(0, 998)) - 499
                     : 12345;
      step(1'b0, rdy, 1'b0);
      waited++;
    end
    check("b_freeze_timeout", b_valid, 1);
    full_chk = 1;
    for (int c = 0; c < 4; c++) xin[c] = 77;
    step(1'b0, 1'b1, 1'b0);
    check("b_w2_128", $signed(b_window[2][128]), 1000);
    check("b_ovr_set", b_ovr, 1);
    step(1'b0, 1'b1, 1'b1);
    check("b_ack_valid", b_valid, 0);
    full_chk = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
